vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator with pixel-clock-enable divider, programmable porch/sync widths, and programmable sync polarity.
- Emits pixel coordinates to an upstream pixel source, plus frame/line strobes.
- Delays sync and data-enable by a programmable pipeline depth so they stay aligned with colour data returned from the source.
- Sits between the game/CPU pixel renderer and the board VGA DAC pins.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock-enable divider, x/y counters,
// programmable sync windows/polarity and a PIPE-tick delay to match source latency.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 4,
    parameter int PIPE     = 1,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_ce,
    output logic             vga_clk,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    input  logic [CW-1:0]    r_in,
    input  logic [CW-1:0]    g_in,
    input  logic [CW-1:0]    b_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CW-1:0]    r,
    output logic [CW-1:0]    g,
    output logic [CW-1:0]    b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    // One extra bit so a sync window ending exactly at TOTAL cannot wrap to 0.
    localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             run;
    logic             x_last;
    logic             y_last;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       raw_bus;
    logic [2:0]       dly_bus;

    assign run    = en & ~rst;
    assign pix_ce = run & (div == DIV_LAST);
    assign x_last = (x == H_LAST);
    assign y_last = (y == V_LAST);

    assign line_start  = pix_ce & x_last;
    assign frame_start = pix_ce & x_last & y_last;

    assign active  = (x < H_VIS) && (y < V_VIS);
    assign hs_raw  = (x >= HS_BEG) && ({1'b0, x} < HS_END);
    assign vs_raw  = (y >= VS_BEG) && ({1'b0, y} < VS_END);
    assign raw_bus = {hs_raw, vs_raw, active};

    generate
        if (CLK_DIV == 1) begin : g_vclk_off
            assign vga_clk = 1'b0;
        end else begin : g_vclk_div
            assign vga_clk = (div >= DIV_HALF);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!run) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Sync/de delay line, advancing one stage per pixel tick.
    generate
        if (PIPE == 0) begin : g_no_pipe
            assign dly_bus = raw_bus;
        end else begin : g_pipe
            logic [2:0] stage [PIPE];
            always_ff @(posedge clk) begin
                if (!run) begin
                    for (int i = 0; i < PIPE; i++) stage[i] <= 3'b000;
                end else if (pix_ce) begin
                    stage[0] <= raw_bus;
                    for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
                end
            end
            assign dly_bus = stage[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!run) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else if (pix_ce) begin
            hsync <= dly_bus[2] ? HS_POL : ~HS_POL;
            vsync <= dly_bus[1] ? VS_POL : ~VS_POL;
            de    <= dly_bus[0];
            r     <= dly_bus[0] ? r_in : '0;
            g     <= dly_bus[0] ? g_in : '0;
            b     <= dly_bus[0] ? b_in : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised en/rst stimulus on four differently parameterised generators,
// each checked every clk against a tick-count based raster model.
module tb_vga_timing_gen;
    localparam int N = 4;
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;

    typedef struct {
        int d, ha, hf, hs, hb, va, vf, vs, vb, hp, vp, p;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    wire        pce [N];
    wire        vclk[N];
    wire        act [N];
    wire        ls  [N];
    wire        fs  [N];
    wire        hs  [N];
    wire        vs  [N];
    wire        de  [N];
    wire [10:0] ox  [N];
    wire [10:0] oy  [N];
    wire [3:0]  orr [N];
    wire [3:0]  og  [N];
    wire [3:0]  ob  [N];
    logic [3:0] ri  [N];
    logic [3:0] gi  [N];
    logic [3:0] bi  [N];

    cfg_t   cfg[N];
    int     c[N];
    longint k[N];
    int     salt;
    int     n_checks = 0;
    int     n_errors = 0;

    vga_timing_gen #(.PIPE(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce[0]), .vga_clk(vclk[0]),
        .x(ox[0]), .y(oy[0]), .active(act[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .r_in(ri[0]), .g_in(gi[0]), .b_in(bi[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .r(orr[0]), .g(og[0]), .b(ob[0]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .HS_POL(1), .VS_POL(1),
        .PIPE(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce[1]), .vga_clk(vclk[1]),
        .x(ox[1]), .y(oy[1]), .active(act[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .r_in(ri[1]), .g_in(gi[1]), .b_in(bi[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .r(orr[1]), .g(og[1]), .b(ob[1]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .HS_POL(1), .VS_POL(1),
        .PIPE(4)) u2 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce[2]), .vga_clk(vclk[2]),
        .x(ox[2]), .y(oy[2]), .active(act[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .r_in(ri[2]), .g_in(gi[2]), .b_in(bi[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .r(orr[2]), .g(og[2]), .b(ob[2]));

    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce[3]), .vga_clk(vclk[3]),
        .x(ox[3]), .y(oy[3]), .active(act[3]), .line_start(ls[3]), .frame_start(fs[3]),
        .r_in(ri[3]), .g_in(gi[3]), .b_in(bi[3]), .hsync(hs[3]), .vsync(vs[3]), .de(de[3]),
        .r(orr[3]), .g(og[3]), .b(ob[3]));

    task automatic chk(input int inst, input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL u%0d.%s got %0d expected %0d at %0t", inst, tag, got, exp, $time);
        end
    endtask

    function automatic int htot(input int i);
        return cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    endfunction

    function automatic int vtot(input int i);
        return cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
    endfunction

    // Raster position after n pixel ticks from a clean restart.
    task automatic pos(input int i, input longint n, output int px, output int py);
        px = int'(n % longint'(htot(i)));
        py = int'((n / longint'(htot(i))) % longint'(vtot(i)));
    endtask

    task automatic colour(input int px, input int py, output logic [3:0] cr,
                          output logic [3:0] cg, output logic [3:0] cb);
        cr = 4'(px);
        cg = 4'(px + 3 * py + salt);
        cb = 4'(py ^ salt);
    endtask

    task automatic chk_out(input int i);
        int px, py, hx, hy;
        logic ha, va, dv;
        logic [3:0] cr, cg, cb;
        pos(i, k[i], px, py);
        chk(i, "x", ox[i], px);
        chk(i, "y", oy[i], py);
        chk(i, "active", act[i], (px < cfg[i].ha && py < cfg[i].va));
        if (k[i] >= longint'(cfg[i].p + 1)) begin
            pos(i, k[i] - cfg[i].p - 1, hx, hy);
            ha = (hx >= cfg[i].ha + cfg[i].hf) && (hx < cfg[i].ha + cfg[i].hf + cfg[i].hs);
            va = (hy >= cfg[i].va + cfg[i].vf) && (hy < cfg[i].va + cfg[i].vf + cfg[i].vs);
            dv = (hx < cfg[i].ha) && (hy < cfg[i].va);
            colour(hx, hy, cr, cg, cb);
        end else begin
            ha = 1'b0; va = 1'b0; dv = 1'b0;
            cr = 4'd0; cg = 4'd0; cb = 4'd0;
        end
        chk(i, "hsync", hs[i], ha ? cfg[i].hp : 1 - cfg[i].hp);
        chk(i, "vsync", vs[i], va ? cfg[i].vp : 1 - cfg[i].vp);
        chk(i, "de", de[i], dv);
        chk(i, "r", orr[i], dv ? cr : 4'd0);
        chk(i, "g", og[i], dv ? cg : 4'd0);
        chk(i, "b", ob[i], dv ? cb : 4'd0);
    endtask

    // One clk: check outputs, apply inputs, check strobes, advance model, wait.
    task automatic step(input logic nrst, input logic nen);
        int px, py;
        logic ep;
        for (int i = 0; i < N; i++) chk_out(i);
        rst = nrst;
        en  = nen;
        for (int i = 0; i < N; i++) begin
            if (k[i] >= longint'(cfg[i].p)) begin
                pos(i, k[i] - cfg[i].p, px, py);
                colour(px, py, ri[i], gi[i], bi[i]);
            end else begin
                ri[i] = 4'd0; gi[i] = 4'd0; bi[i] = 4'd0;
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            pos(i, k[i], px, py);
            ep = !nrst && nen && (c[i] == cfg[i].d - 1);
            chk(i, "pix_ce", pce[i], ep);
            chk(i, "vga_clk", vclk[i], (cfg[i].d > 1) && (c[i] >= cfg[i].d / 2));
            chk(i, "line_start", ls[i], ep && (px == htot(i) - 1));
            chk(i, "frame_start", fs[i], ep && (px == htot(i) - 1) && (py == vtot(i) - 1));
            if (nrst || !nen) begin
                c[i] = 0;
                k[i] = 0;
            end else begin
                if (ep) k[i]++;
                c[i] = (c[i] + 1) % cfg[i].d;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt, seg, kind, len, steps;
        salt   = int'($urandom_range(0, 15));
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
        cfg[1] = '{1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, 1, 0};
        cfg[2] = '{1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, 1, 4};
        cfg[3] = '{3, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 0, 0, 2};
        for (int i = 0; i < N; i++) begin
            c[i] = 0; k[i] = 0;
            ri[i] = 4'd0; gi[i] = 4'd0; bi[i] = 4'd0;
        end
        repeat (3) @(negedge clk);
        step(1'b1, 1'b1);

        // Run into line 1 of the default raster, drop en at x=300, then restart.
        for (int s = 0; s < 2 * (800 + 300); s++) step(1'b0, 1'b1);
        chk(0, "drop_x", ox[0], 300);
        chk(0, "drop_y", oy[0], 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cnt = 0;
        while (ox[0] != 11'd1 && cnt < 20) begin
            step(1'b0, 1'b1);
            cnt++;
        end
        chk(0, "restart_clks", cnt, 2);

        // Rst with en still high, then random run/interrupt segments.
        step(1'b1, 1'b1);
        steps = 0;
        while (steps < 36000) begin
            seg = int'($urandom_range(300, 5000));
            for (int s = 0; s < seg; s++) step(1'b0, 1'b1);
            kind = int'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 4));
            for (int s = 0; s < len; s++) begin
                if (kind == 0) step(1'b0, 1'b0);
                else if (kind == 1) step(1'b1, 1'b1);
                else step(1'b1, 1'b0);
            end
            steps += seg + len;
        end
        step(1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
